// File: rtl/parity_check_unit.sv
// Receive-side parity checker: assembles LSB-first data bits of a serial frame,
// checks the parity bit against the latched mode and keeps a saturating error count.
module parity_check_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  parity_checker_enable,
    input  logic                  sample_strobe,
    input  logic [3:0]            bit_cnt,
    input  logic                  sampled_bit,
    input  logic [3:0]            DATA_LEN,
    input  logic [2:0]            PAR_MODE,
    input  logic                  err_cnt_clr,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  parity_error,
    output logic                  par_chk_done,
    output logic                  cfg_error,
    output logic                  seq_error,
    output logic [ERR_CNT_W-1:0]  err_cnt
);

    typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

    localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  par_q, par_d;
    logic [3:0]            len_q, len_d;
    logic [2:0]            mode_q, mode_d;
    logic [3:0]            idx_q, idx_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic                  par_err_q, par_err_d;
    logic                  done_q, done_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  seq_err_q, seq_err_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

    logic cfg_legal;
    logic complete;
    logic frame_err;
    logic exp_par;

    assign cfg_legal = (DATA_LEN >= 4'd5) && (DATA_LEN <= MAX_LEN) && (PAR_MODE <= 3'd4);

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        par_d     = par_q;
        len_d     = len_q;
        mode_d    = mode_q;
        idx_d     = idx_q;
        p_data_d  = p_data_q;
        par_err_d = par_err_q;
        done_d    = 1'b0;
        cfg_err_d = 1'b0;
        seq_err_d = 1'b0;
        complete  = 1'b0;
        frame_err = 1'b0;

        case (mode_q)
            3'd1:    exp_par = par_q;
            3'd2:    exp_par = ~par_q;
            3'd3:    exp_par = 1'b1;
            default: exp_par = 1'b0;
        endcase

        if (!parity_checker_enable) begin
            state_d = IDLE;
        end else if (sample_strobe) begin
            // A start bit restarts the frame from any state.
            if (bit_cnt == 4'd0) begin
                if (cfg_legal) begin
                    state_d = DATA;
                    len_d   = DATA_LEN;
                    mode_d  = PAR_MODE;
                    data_d  = '0;
                    par_d   = 1'b0;
                    idx_d   = 4'd1;
                end else begin
                    state_d   = IDLE;
                    cfg_err_d = 1'b1;
                end
            end else begin
                case (state_q)
                    DATA: begin
                        if (bit_cnt == idx_q) begin
                            for (int i = 0; i < DATA_WIDTH; i++) begin
                                if (idx_q == 4'(i + 1)) data_d[i] = sampled_bit;
                            end
                            par_d = par_q ^ sampled_bit;
                            idx_d = idx_q + 4'd1;
                            if (idx_q == len_q) begin
                                if (mode_q == 3'd0) begin
                                    complete = 1'b1;
                                    state_d  = IDLE;
                                end else begin
                                    state_d = PARITY;
                                end
                            end
                        end else begin
                            seq_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    PARITY: begin
                        if (bit_cnt == idx_q) begin
                            complete  = 1'b1;
                            frame_err = (sampled_bit != exp_par);
                            state_d   = IDLE;
                        end else begin
                            seq_err_d = 1'b1;
                            state_d   = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (complete) begin
            p_data_d  = data_d;
            par_err_d = frame_err;
            done_d    = 1'b1;
        end

        err_cnt_d = err_cnt_q;
        if (complete && frame_err && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
        if (err_cnt_clr) err_cnt_d = '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            data_q    <= '0;
            par_q     <= 1'b0;
            len_q     <= '0;
            mode_q    <= '0;
            idx_q     <= '0;
            p_data_q  <= '0;
            par_err_q <= 1'b0;
            done_q    <= 1'b0;
            cfg_err_q <= 1'b0;
            seq_err_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            par_q     <= par_d;
            len_q     <= len_d;
            mode_q    <= mode_d;
            idx_q     <= idx_d;
            p_data_q  <= p_data_d;
            par_err_q <= par_err_d;
            done_q    <= done_d;
            cfg_err_q <= cfg_err_d;
            seq_err_q <= seq_err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign P_DATA       = p_data_q;
    assign parity_error = par_err_q;
    assign par_chk_done = done_q;
    assign cfg_error    = cfg_err_q;
    assign seq_error    = seq_err_q;
    assign err_cnt      = err_cnt_q;

endmodule
